// File: rtl/pipelined_barrel_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// pipelined_barrel_shifter: log-depth variable shifter (SLL/SRL/SRA/ROR), one stage per
// shift-amount bit, valid/ready on both sides with whole-pipeline stall.
module pipelined_barrel_shifter #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_vld_i,
  output logic                 a_rdy_o,
  input  logic [N-1:0]         a_i,
  input  logic [$clog2(N)-1:0] shamt_i,
  input  logic [1:0]           op_i,
  output logic                 res_vld_o,
  input  logic                 res_rdy_i,
  output logic [N-1:0]         res_o
);

  localparam int L = $clog2(N);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Element k feeds stage k; element L is the output of the last stage.
  logic [L:0][N-1:0]   data_pipe;
  logic [L:0]          vld_pipe;
  logic [L-1:0][1:0]   op_pipe;
  logic                adv;

  assign adv          = !vld_pipe[L] || res_rdy_i;
  assign a_rdy_o      = adv;
  assign data_pipe[0] = a_i;
  assign vld_pipe[0]  = a_vld_i;
  assign op_pipe[0]   = op_i;
  assign res_o        = data_pipe[L];
  assign res_vld_o    = vld_pipe[L];

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int SH = 1 << k;
    // Stage k only needs shamt bits k and above, so the forwarded amount narrows each stage.
    localparam int SW = L - k;

    logic [SW-1:0] sh_in;
    logic [N-1:0]  d_in;
    logic [N-1:0]  shifted;
    logic [N-1:0]  data_d;
    logic [N-1:0]  data_q;
    logic          vld_q;

    if (k == 0) begin : g_head
      assign sh_in = shamt_i;
    end else begin : g_body
      assign sh_in = g_stage[k-1].g_fwd.sh_q;
    end

    assign d_in = data_pipe[k];

    always_comb begin
      shifted = d_in;
      case (op_pipe[k])
        OP_SLL:  shifted = {d_in[N-SH-1:0], {SH{1'b0}}};
        OP_SRL:  shifted = {{SH{1'b0}}, d_in[N-1:SH]};
        OP_SRA:  shifted = {{SH{d_in[N-1]}}, d_in[N-1:SH]};
        OP_ROR:  shifted = {d_in[SH-1:0], d_in[N-1:SH]};
        default: shifted = d_in;
      endcase
      data_d = sh_in[0] ? shifted : d_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        vld_q  <= 1'b0;
      end else if (adv) begin
        data_q <= data_d;
        vld_q  <= vld_pipe[k];
      end
    end

    assign data_pipe[k+1] = data_q;
    assign vld_pipe[k+1]  = vld_q;

    if (k < L - 1) begin : g_fwd
      logic [SW-2:0] sh_q;
      logic [1:0]    op_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_q <= '0;
          op_q <= '0;
        end else if (adv) begin
          sh_q <= sh_in[SW-1:1];
          op_q <= op_pipe[k];
        end
      end

      assign op_pipe[k+1] = op_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// tb_pipelined_barrel_shifter: directed self-checking bench for the pipelined barrel shifter.
module tb_pipelined_barrel_shifter;
  localparam int N = 8;
  localparam int L = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         a_vld = 1'b0;
  logic         a_rdy;
  logic [N-1:0] a = '0;
  logic [L-1:0] shamt = '0;
  logic [1:0]   op = '0;
  logic         res_vld;
  logic         res_rdy = 1'b0;
  logic [N-1:0] res;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_vld_i   (a_vld),
    .a_rdy_o   (a_rdy),
    .a_i       (a),
    .shamt_i   (shamt),
    .op_i      (op),
    .res_vld_o (res_vld),
    .res_rdy_i (res_rdy),
    .res_o     (res)
  );

  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] v, input logic [L-1:0] s,
                                             input logic [1:0] o);
    logic signed [N-1:0] sv;
    sv = v;
    case (o)
      2'b00:   return v << s;
      2'b01:   return v >> s;
      2'b10:   return sv >>> s;
      default: return (v >> s) | (v << (N - int'(s)));
    endcase
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: res_vld=%b expected 0", res_vld); end
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: a_rdy=%b expected 1", a_rdy); end
    checks++; if (res !== 8'h00) begin errors++; $display("FAIL reset_res: res=%h expected 00", res); end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (res_vld !== 1'b0 || a_rdy !== 1'b1) begin
        errors++; $display("FAIL idle: res_vld=%b a_rdy=%b expected 0/1", res_vld, a_rdy);
      end
    end
  endtask

  task automatic test_single(input logic [N-1:0] av, input logic [L-1:0] sv, input logic [1:0] ov,
                             input logic [N-1:0] exp, input string name);
    @(negedge clk);
    res_rdy = 1'b1; a = av; shamt = sv; op = ov; a_vld = 1'b1;
    #1;
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL %s_accept: a_rdy=%b expected 1", name, a_rdy); end
    for (int c = 1; c <= L + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        a_vld = 1'b0; a = ~av; shamt = ~sv; op = ~ov;
      end
      checks++;
      if (c == L) begin
        if (res_vld !== 1'b1 || res !== exp) begin
          errors++; $display("FAIL %s: res_vld=%b res=%h expected 1/%h", name, res_vld, res, exp);
        end
      end else if (res_vld !== 1'b0) begin
        errors++; $display("FAIL %s_latency: cycle %0d res_vld=%b expected 0", name, c, res_vld);
      end
    end
  endtask

  task automatic test_ops();
    test_single(8'b1001_0110, 3'd3, 2'b00, 8'b1011_0000, "sll3");
    test_single(8'b1001_0110, 3'd3, 2'b01, 8'b0001_0010, "srl3");
    test_single(8'b1001_0110, 3'd3, 2'b10, 8'b1111_0010, "sra3");
    test_single(8'b1001_0110, 3'd3, 2'b11, 8'b1101_0010, "ror3");
  endtask

  task automatic test_edges();
    test_single(8'h81, 3'd7, 2'b10, 8'hFF, "sra7");
    test_single(8'h81, 3'd7, 2'b01, 8'h01, "srl7");
    test_single(8'h81, 3'd7, 2'b00, 8'h80, "sll7");
    test_single(8'h81, 3'd7, 2'b11, 8'h03, "ror7");
    for (int o = 0; o < 4; o++) test_single(8'hA5, 3'd0, o[1:0], 8'hA5, "zero_amt");
  endtask

  task automatic run_stream(input int n, input int stall_at, input int stall_len, input string name);
    logic [N-1:0] va[32];
    logic [L-1:0] vs[32];
    logic [1:0]   vo[32];
    logic [N-1:0] exp_q[$];
    logic [N-1:0] held;
    int sent, got, cyc;
    logic stall;
    for (int i = 0; i < n; i++) begin
      va[i] = N'($urandom); vs[i] = L'($urandom); vo[i] = 2'($urandom);
    end
    sent = 0; got = 0; cyc = 0; held = '0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      res_rdy = !stall;
      if (sent < n) begin
        a_vld = 1'b1; a = va[sent]; shamt = vs[sent]; op = vo[sent];
      end else begin
        a_vld = 1'b0;
      end
      #1;
      if (res_vld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s_extra: unexpected result %h", name, res);
        end else if (res !== exp_q[0]) begin
          errors++; $display("FAIL %s_data: res=%h expected %h (result %0d)", name, res, exp_q[0], got);
        end
        if (res_rdy) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          got++;
        end
      end
      if (stall) begin
        checks++;
        if (a_rdy !== 1'b0) begin errors++; $display("FAIL %s_stall_rdy: a_rdy=%b expected 0", name, a_rdy); end
        if (cyc > stall_at) begin
          checks++;
          if (res !== held) begin errors++; $display("FAIL %s_hold: res=%h expected %h", name, res, held); end
        end
        held = res;
      end
      if (a_vld && a_rdy) begin
        exp_q.push_back(ref_shift(a, shamt, op));
        sent++;
      end
      cyc++;
    end
    a_vld = 1'b0;
    res_rdy = 1'b1;
    checks++;
    if (got != n) begin errors++; $display("FAIL %s_count: got %0d results expected %0d", name, got, n); end
    checks++;
    if (cyc != n + L + stall_len) begin
      errors++; $display("FAIL %s_cycles: took %0d cycles expected %0d", name, cyc, n + L + stall_len);
    end
    @(negedge clk);
    checks++;
    if (res_vld !== 1'b0) begin errors++; $display("FAIL %s_dup: res_vld=%b expected 0", name, res_vld); end
  endtask

  task automatic test_back_to_back();
    run_stream(20, 1000, 0, "stream");
  endtask

  task automatic test_backpressure();
    run_stream(6, 5, 4, "bp");
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    res_rdy = 1'b1; a_vld = 1'b1; a = 8'h3C; shamt = 3'd1; op = 2'b00;
    @(negedge clk);
    a = 8'h0F; shamt = 3'd2; op = 2'b11;
    @(negedge clk);
    a_vld = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (res_vld !== 1'b0 || a_rdy !== 1'b1 || res !== 8'h00) begin
      errors++; $display("FAIL midreset: res_vld=%b a_rdy=%b res=%h expected 0/1/00", res_vld, a_rdy, res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (res_vld !== 1'b0) begin errors++; $display("FAIL midreset_drop: cycle %0d res_vld=%b expected 0", c, res_vld); end
    end
    test_single(8'h5A, 3'd4, 2'b11, 8'hA5, "after_reset");
  endtask

  initial begin
    test_reset();
    test_ops();
    test_edges();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Variable-amount shifter for the arithmetic/pipelining library; complements the fixed constant-amount shift blocks.
- Covers the opposite shift direction plus signed and rotate variants, with a runtime shift amount.
- Log-depth pipeline: one stage per shift-amount bit, each stage conditionally shifts by 2^k.
- Valid/ready handshake on both sides, with whole-pipeline stall under backpressure.

Parameters:
- N, 8, data width in bits; must be a power of two and at least 2.
- L, $clog2(N), number of pipeline stages and width of the shift amount; derived, not to be overridden.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, reset, asynchronous, active-low.
- a_vld, input, 1, input operand valid.
- a_rdy, output, 1, shifter can accept an operand this cycle.
- a, input, N, operand.
- shamt, input, L, shift amount 0..N-1.
- op, input, 2, operation select: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
- res_vld, output, 1, result valid.
- res_rdy, input, 1, downstream accepts result.
- res, output, N, shifted result.

Behaviour:
- Reset (rst low, asynchronous): all stage valid bits cleared, so res_vld = 0 immediately.
  - res and internal data/shamt/op registers reset to 0.
  - a_rdy = 1 while in reset.
  - A transaction in flight when reset asserts is dropped; nothing is output after release.
- Advance condition: adv = !res_vld || res_rdy.
  - a_rdy = adv, combinational.
  - When adv = 0 every stage register holds, including valid bits and data.
  - When adv = 1 every stage loads from its predecessor.
  - There is no per-stage bubble collapsing.
- Input acceptance: an operand is accepted when a_vld && a_rdy at a rising edge.
  - Stage 0 valid loads a_vld when adv = 1; an unaccepted a_vld is never captured.
- Stage k, for k = 0..L-1:
  - Takes data d, op, shamt from stage k-1 (stage 0 takes them from the input ports).
  - If shamt[k] = 1, outputs d shifted by 2^k per op; otherwise outputs d unchanged.
  - Registers data, op, shamt and valid.
  - 00: vacated low bits filled with 0.
  - 01: vacated high bits filled with 0.
  - 10: vacated high bits filled with d[N-1], the sign bit of the current stage value, which equals the original sign.
  - 11: bits leaving the LSB end re-enter at the MSB end.
- Output: res and res_vld are the registered outputs of stage L-1; no combinational path from a to res.
- Latency: exactly L cycles from acceptance to res_vld with no stall; each stall cycle adds one cycle.
- Throughput: one result per cycle while res_rdy = 1.
- Result hold: res and res_vld hold stable while res_vld && !res_rdy.
- Boundary conditions:
  - shamt = 0: res = a for all ops.
  - shamt = N-1: full-width shift.
  - Simultaneous res handshake and a_vld in the same cycle: both complete, no loss and no duplication.
  - a, shamt and op are sampled only at acceptance; later changes do not affect in-flight results.
  - res_rdy may be 1 with no valid output; nothing happens.
- Arithmetic: unsigned treatment for ops 00/01/11; two's complement sign extension only for op 10.
- No overflow flags; bits shifted out are discarded.

Test Plan (N=8, L=3):
- Reset then idle: rst low, then high; a_vld=0 -> res_vld=0 and a_rdy=1 indefinitely.
- Single ops, each with a=8'b1001_0110, shamt=3, res_rdy=1 -> res_vld exactly 3 cycles after acceptance, with:
  - op=00 -> res=8'b1011_0000
  - op=01 -> 8'b0001_0010
  - op=10 -> 8'b1111_0010
  - op=11 -> 8'b1101_0010
- Edge amounts:
  - a=8'h81, op=10, shamt=7 -> 8'hFF
  - a=8'h81, op=01, shamt=7 -> 8'h01
  - a=8'h81, op=00, shamt=7 -> 8'h80
  - a=8'hA5, shamt=0, any op -> 8'hA5
- Streaming: 20 back-to-back random operands, res_rdy=1 -> 20 results in order, one per cycle, each equal to the reference model (<<, >>, >>>, rotate).
- Backpressure:
  - Stream 6 operands; drop res_rdy for 4 cycles mid-stream -> a_rdy=0 during the stall.
  - res is held stable throughout the stall.
  - After release, all 6 results arrive in order with no loss or duplication.
- Reset mid-flight: accept 2 operands, assert rst for 1 cycle before the first emerges -> res_vld=0 immediately and stays 0 afterwards until new inputs arrive.
